// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, round-constant handling and key-schedule states.
package aes_pkg;

   localparam int unsigned AES_KEY_W  = 128;
   localparam int unsigned AES_WORD_W = 32;
   localparam int unsigned AES_BYTE_W = 8;

   localparam logic [AES_BYTE_W-1:0] RCON_INIT = 8'h01;
   localparam logic [AES_BYTE_W-1:0] RCON_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      SUB   = 2'd2
   } state_e;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [AES_BYTE_W-1:0] xtime(input logic [AES_BYTE_W-1:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage : aes_pkg

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared with the SubBytes datapath.
//   byte_i   : input byte
//   byte_c   : substituted byte (combinational)
module aes_sbox
   import aes_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] byte_i,
   output logic [AES_BYTE_W-1:0] byte_c
);

   // Entry 0 is the leftmost byte of the first row.
   localparam logic [0:255][AES_BYTE_W-1:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign byte_c = SBOX[byte_i];

endmodule : aes_sbox

// File: rtl/aes_key_expand.sv
// AES-128 on-the-fly key schedule: derives each round key from the previous one
// in two cycles (S1: SubWord/RotWord/rcon, S2: word XOR chain).
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture key_in as the round-0 key (wins over expand_en)
//   key_in     : cipher key, byte 0 in bits [127:120]
//   expand_en  : request the next round key
//   round_key  : current round key
//   round_num  : index of round_key (0..NUM_ROUNDS)
//   busy       : derivation in flight
//   key_ready  : round_key valid and stable
//   last_key   : round_num == NUM_ROUNDS
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [AES_KEY_W-1:0] key_in,
   input  logic                 expand_en,
   output logic [AES_KEY_W-1:0] round_key,
   output logic [3:0]           round_num,
   output logic                 busy,
   output logic                 key_ready,
   output logic                 last_key
);

   localparam int unsigned RN_W = 4;

   state_e                 state_q,     state_d;
   logic [AES_KEY_W-1:0]   round_key_q, round_key_d;
   logic [RN_W-1:0]        round_num_q, round_num_d;
   logic [AES_BYTE_W-1:0]  rcon_q,      rcon_d;
   logic [AES_WORD_W-1:0]  tmp_q,       tmp_d;
   logic                   busy_q,      busy_d;
   logic                   key_ready_q, key_ready_d;
   logic                   last_key_q,  last_key_d;

   logic [AES_WORD_W-1:0]  w0, w1, w2, w3;
   logic [AES_WORD_W-1:0]  w0_n, w1_n, w2_n, w3_n;
   logic [AES_WORD_W-1:0]  rot_w3, sub_w3;

   assign w0 = round_key_q[127:96];
   assign w1 = round_key_q[95:64];
   assign w2 = round_key_q[63:32];
   assign w3 = round_key_q[31:0];

   // RotWord: {a,b,c,d} -> {b,c,d,a}
   assign rot_w3 = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .byte_i (rot_w3[i*AES_BYTE_W +: AES_BYTE_W]),
         .byte_c (sub_w3[i*AES_BYTE_W +: AES_BYTE_W])
      );
   end

   // Stage-2 XOR chain from the registered stage-1 word.
   assign w0_n = w0 ^ tmp_q;
   assign w1_n = w1 ^ w0_n;
   assign w2_n = w2 ^ w1_n;
   assign w3_n = w3 ^ w2_n;

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      round_key_d = round_key_q;
      round_num_d = round_num_q;
      rcon_d      = rcon_q;
      tmp_d       = tmp_q;
      busy_d      = busy_q;
      key_ready_d = key_ready_q;
      last_key_d  = last_key_q;

      if (load) begin
         // Abort any derivation; the stage-1 word is dropped.
         state_d     = READY;
         round_key_d = key_in;
         round_num_d = '0;
         rcon_d      = RCON_INIT;
         tmp_d       = '0;
         busy_d      = 1'b0;
         key_ready_d = 1'b1;
         last_key_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            READY: begin
               if (expand_en && (round_num_q != RN_W'(NUM_ROUNDS))) begin
                  state_d     = SUB;
                  tmp_d       = sub_w3 ^ {rcon_q, 24'h000000};
                  busy_d      = 1'b1;
                  key_ready_d = 1'b0;
               end
            end
            SUB: begin
               state_d     = READY;
               round_key_d = {w0_n, w1_n, w2_n, w3_n};
               round_num_d = round_num_q + RN_W'(1);
               rcon_d      = xtime(rcon_q);
               busy_d      = 1'b0;
               key_ready_d = 1'b1;
               last_key_d  = ((round_num_q + RN_W'(1)) == RN_W'(NUM_ROUNDS));
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         round_key_q <= '0;
         round_num_q <= '0;
         rcon_q      <= RCON_INIT;
         tmp_q       <= '0;
         busy_q      <= 1'b0;
         key_ready_q <= 1'b0;
         last_key_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_key_q <= round_key_d;
         round_num_q <= round_num_d;
         rcon_q      <= rcon_d;
         tmp_q       <= tmp_d;
         busy_q      <= busy_d;
         key_ready_q <= key_ready_d;
         last_key_q  <= last_key_d;
      end
   end

   assign round_key = round_key_q;
   assign round_num = round_num_q;
   assign busy      = busy_q;
   assign key_ready = key_ready_q;
   assign last_key  = last_key_q;

endmodule : aes_key_expand

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using the FIPS-197 appendix A.1 key schedule.
module tb_aes_key_expand;

   logic         clk;
   logic         reset;
   logic         load;
   logic [127:0] key_in;
   logic         expand_en;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         busy;
   logic         key_ready;
   logic         last_key;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_ALT = 128'h000102030405060708090a0b0c0d0e0f;

   logic [127:0] exp_rk [0:10];

   aes_key_expand #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .key_in    (key_in),
      .expand_en (expand_en),
      .round_key (round_key),
      .round_num (round_num),
      .busy      (busy),
      .key_ready (key_ready),
      .last_key  (last_key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_key"},   round_key, 128'h0);
      check({tag, "_num"},   128'(round_num), 128'h0);
      check({tag, "_busy"},  128'(busy), 128'h0);
      check({tag, "_ready"}, 128'(key_ready), 128'h0);
      check({tag, "_last"},  128'(last_key), 128'h0);
   endtask

   task automatic do_load(input logic [127:0] k);
      key_in = k;
      load   = 1'b1;
      tick();
      load   = 1'b0;
   endtask

   // Single expand_en pulse, checking the S1 handshake and the S2 result.
   task automatic do_expand(input int r);
      expand_en = 1'b1;
      tick();
      expand_en = 1'b0;
      check($sformatf("s1_busy_r%0d", r),  128'(busy), 128'h1);
      check($sformatf("s1_ready_r%0d", r), 128'(key_ready), 128'h0);
      tick();
      check($sformatf("rk_r%0d", r),    round_key, exp_rk[r]);
      check($sformatf("num_r%0d", r),   128'(round_num), 128'(r));
      check($sformatf("busy_r%0d", r),  128'(busy), 128'h0);
      check($sformatf("ready_r%0d", r), 128'(key_ready), 128'h1);
      check($sformatf("last_r%0d", r),  128'(last_key), (r == 10) ? 128'h1 : 128'h0);
   endtask

   initial begin
      exp_rk[0]  = KEY0;
      exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset     = 1'b1;
      load      = 1'b0;
      key_in    = '0;
      expand_en = 1'b0;
      #1;
      check_zero("reset");
      tick();
      tick();
      reset = 1'b0;
      tick();

      // expand_en in IDLE is ignored
      expand_en = 1'b1;
      tick();
      expand_en = 1'b0;
      check("idle_busy", 128'(busy), 128'h0);
      tick();
      check_zero("idle_exp");

      // load
      do_load(KEY0);
      check("load_key",   round_key, KEY0);
      check("load_num",   128'(round_num), 128'h0);
      check("load_ready", 128'(key_ready), 128'h1);
      check("load_busy",  128'(busy), 128'h0);

      // key_in changes without load have no effect
      key_in = KEY_ALT;
      tick();
      check("keyin_hold", round_key, KEY0);

      do_expand(1);
      check("busy_gone", 128'(busy), 128'h0);

      // back-to-back expand_en: second pulse lands in SUB and is dropped
      expand_en = 1'b1;
      tick();
      check("b2b_busy", 128'(busy), 128'h1);
      tick();
      expand_en = 1'b0;
      check("b2b_num", 128'(round_num), 128'h2);
      check("b2b_rk",  round_key, exp_rk[2]);
      tick();
      tick();
      check("b2b_num_hold", 128'(round_num), 128'h2);
      check("b2b_busy_idle", 128'(busy), 128'h0);

      for (int r = 3; r <= 10; r++) begin
         do_expand(r);
         tick();
         tick();
      end

      // expand_en at the last round is ignored
      expand_en = 1'b1;
      tick();
      expand_en = 1'b0;
      check("last_busy", 128'(busy), 128'h0);
      tick();
      check("last_rk",   round_key, exp_rk[10]);
      check("last_num",  128'(round_num), 128'd10);
      check("last_flag", 128'(last_key), 128'h1);

      // load and expand_en together: load wins
      key_in    = KEY0;
      load      = 1'b1;
      expand_en = 1'b1;
      tick();
      load      = 1'b0;
      expand_en = 1'b0;
      check("ldex_key",  round_key, KEY0);
      check("ldex_num",  128'(round_num), 128'h0);
      check("ldex_busy", 128'(busy), 128'h0);
      check("ldex_last", 128'(last_key), 128'h0);
      tick();
      check("ldex_key2", round_key, KEY0);

      // load during S1 aborts the derivation
      expand_en = 1'b1;
      tick();
      expand_en = 1'b0;
      check("ldS1_busy", 128'(busy), 128'h1);
      do_load(KEY_ALT);
      check("ldS1_key",   round_key, KEY_ALT);
      check("ldS1_num",   128'(round_num), 128'h0);
      check("ldS1_busy2", 128'(busy), 128'h0);
      tick();
      check("ldS1_nostale", round_key, KEY_ALT);
      check("ldS1_num2",    128'(round_num), 128'h0);

      // reset during S1 with rcon already advanced
      do_load(KEY0);
      do_expand(1);
      expand_en = 1'b1;
      tick();
      expand_en = 1'b0;
      check("rstS1_busy", 128'(busy), 128'h1);
      #2;
      reset = 1'b1;
      #1;
      check_zero("rst_async");
      tick();
      check_zero("rst_hold");
      reset = 1'b0;
      tick();
      check_zero("rst_idle");

      // rcon must have restarted
      do_load(KEY0);
      do_expand(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard bound on run length.
   initial begin
      #100000;
      n_errors++;
      $display("FAIL timeout: got no finish expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   end

endmodule : tb_aes_key_expand
